mul_share_arbiter: RTL and testbench

Shares one `booth_multiplier_16` instance (16x16 signed, combinational, ports `real_x`/`real_y`/`product`) between two requesters in the MCU, such as the ALU MUL path and the DSP/MAC unit. It arbitrates requests, registers the operands, and captures the 32-bit product. It then returns the product to the winning requester over a valid/ready response channel. At most one multiplication is in flight at a time.

---
 rtl/mul_share_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mul_share_arbiter (with booth_multiplier_16)              |
// | Purpose  : Shares one 16x16 signed combinational multiplier between  |
// |            two requesters. Arbitration, operand/result registers,    |
// |            and a valid/ready response channel per requester.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+

module booth_multiplier_16 (
    input  logic [15:0] real_x,
    input  logic [15:0] real_y,
    output logic [31:0] product
);
    logic [31:0] x_ext;
    logic [16:0] y_ext;
    logic [31:0] acc;
    logic [31:0] pp;
    logic [2:0]  trip;

    assign x_ext = {{16{real_x[15]}}, real_x};
    assign y_ext = {real_y, 1'b0};

    // Radix-4 Booth recoding: eight signed partial products summed in 32 bits
    always_comb begin
        acc  = '0;
        pp   = '0;
        trip = '0;
        for (int i = 0; i < 8; i++) begin
            trip = y_ext[2*i +: 3];
            case (trip)
                3'b001, 3'b010: pp = x_ext;
                3'b011:         pp = x_ext << 1;
                3'b100:         pp = -(x_ext << 1);
                3'b101, 3'b110: pp = -x_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2*i));
        end
    end

    assign product = acc;
endmodule

module mul_share_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_product,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_product,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [31:0] res_q, res_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;

    logic        grant_valid;
    logic        grant;
    logic [31:0] mul_product;

    // The single shared multiplier only ever sees the registered operands
    booth_multiplier_16 u_mul (
        .real_x  (op_a_q),
        .real_y  (op_b_q),
        .product (mul_product)
    );

    // Grant selection: a lone requester wins; ties go round-robin or to requester 0
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant       = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = RR_EN ? ~last_grant_q : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready   = (state_q == IDLE) && grant_valid && !grant;
    assign req1_ready   = (state_q == IDLE) && grant_valid &&  grant;
    assign rsp0_valid   = (state_q == RESP) && !owner_q;
    assign rsp1_valid   = (state_q == RESP) &&  owner_q;
    assign rsp0_product = res_q;
    assign rsp1_product = res_q;
    assign busy         = (state_q != IDLE);

    // Next-state and register updates: accept in IDLE, compute one cycle, hold the response
    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        res_d        = res_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    op_a_d       = grant ? req1_a : req0_a;
                    op_b_d       = grant ? req1_b : req0_b;
                    owner_d      = grant;
                    last_grant_d = grant;
                    state_d      = CALC;
                end
            end
            CALC: begin
                res_d   = mul_product;
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last_grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            res_q        <= res_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mul_share_arbiter                                      |
// | Purpose  : Self-checking bench; instance 0 uses round-robin,         |
// |            instance 1 uses fixed priority.                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mul_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rv [2][2];
    logic [15:0] ra [2][2];
    logic [15:0] rb [2][2];
    logic        sr [2][2];
    logic        qr [2][2];
    logic        sv [2][2];
    logic [31:0] sp [2][2];
    logic        bz [2];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          port;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [8];

    int          ngrant, last_g, g_obs, seen1, g, sa, sb;
    bit          m_busy;
    int          m_owner, m_age, m_last;
    logic [31:0] m_prod;
    bit          rsp_on;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mul_share_arbiter #(.RR_EN(k == 0)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req0_valid   (rv[k][0]),
            .req0_ready   (qr[k][0]),
            .req0_a       (ra[k][0]),
            .req0_b       (rb[k][0]),
            .rsp0_valid   (sv[k][0]),
            .rsp0_ready   (sr[k][0]),
            .rsp0_product (sp[k][0]),
            .req1_valid   (rv[k][1]),
            .req1_ready   (qr[k][1]),
            .req1_a       (ra[k][1]),
            .req1_b       (rb[k][1]),
            .rsp1_valid   (sv[k][1]),
            .rsp1_ready   (sr[k][1]),
            .rsp1_product (sp[k][1]),
            .busy         (bz[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk_zero(input int k, input string name);
        chk({name, "_busy"},  32'(bz[k]),    0);
        chk({name, "_rdy0"},  32'(qr[k][0]), 0);
        chk({name, "_rdy1"},  32'(qr[k][1]), 0);
        chk({name, "_vld0"},  32'(sv[k][0]), 0);
        chk({name, "_vld1"},  32'(sv[k][1]), 0);
        chk({name, "_prod0"}, sp[k][0],      0);
        chk({name, "_prod1"}, sp[k][1],      0);
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 2; n++) begin
                rv[k][n] = 1'b0; ra[k][n] = '0; rb[k][n] = '0; sr[k][n] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 16'h0002, 16'h0003, 32'h0000_0006};
        tbl[1] = '{1, 16'hFFFF, 16'h0003, 32'hFFFF_FFFD};
        tbl[2] = '{1, 16'hFFF6, 16'hFFF1, 32'h0000_0096};
        tbl[3] = '{1, 16'hFF61, 16'h0058, 32'hFFFF_C958};
        tbl[4] = '{1, 16'h0000, 16'h006F, 32'h0000_0000};
        tbl[5] = '{0, 16'h8000, 16'h8000, 32'h4000_0000};
        tbl[6] = '{0, 16'h7FFF, 16'h8000, 32'hC000_8000};
        tbl[7] = '{1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001};

        // Reset state, during and after reset
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk_zero(k, "in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk_zero(k, "post_reset");
        @(negedge clk);

        // Table vectors on the round-robin instance, response ready tied high
        for (int i = 0; i < 8; i++) begin
            int n;
            n = tbl[i].port;
            rv[0][n] = 1'b1; ra[0][n] = tbl[i].a; rb[0][n] = tbl[i].b;
            sr[0][n] = 1'b1; sr[0][1-n] = 1'b0;
            #1;
            chk("tbl_accept", 32'(qr[0][n]), 1);
            chk("tbl_other_rdy", 32'(qr[0][1-n]), 0);
            @(negedge clk);
            rv[0][n] = 1'b0;
            #1;
            chk("tbl_calc_busy", 32'(bz[0]), 1);
            chk("tbl_calc_novld", 32'(sv[0][n]), 0);
            @(negedge clk);
            #1;
            chk("tbl_rsp_valid", 32'(sv[0][n]), 1);
            chk("tbl_rsp_other", 32'(sv[0][1-n]), 0);
            chk("tbl_product", sp[0][n], tbl[i].exp);
            @(negedge clk);
        end

        // Round-robin contention: grants 0,1,0,1,...
        do_reset();
        rv[0][0] = 1'b1; ra[0][0] = 16'h029D; rb[0][0] = 16'h03E4;
        rv[0][1] = 1'b1; ra[0][1] = 16'h03E4; rb[0][1] = 16'h029D;
        sr[0][0] = 1'b1; sr[0][1] = 1'b1;
        ngrant = 0; last_g = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (qr[0][0] || qr[0][1]) begin
                g_obs = qr[0][1] ? 1 : 0;
                chk("rr_grant", g_obs, ngrant % 2);
                chk("rr_one_ready", 32'(qr[0][0] & qr[0][1]), 0);
                last_g = g_obs;
                ngrant++;
            end
            if (sv[0][0] || sv[0][1]) begin
                chk("rr_rsp_port", sv[0][1] ? 1 : 0, last_g);
                chk("rr_product", sp[0][last_g], 32'h000A_2AD4);
            end
            @(negedge clk);
        end
        chk("rr_grant_count", ngrant, 10);
        idle_inputs();

        // Fixed priority: requester 1 starves until requester 0 drops
        do_reset();
        rv[1][0] = 1'b1; ra[1][0] = 16'h029D; rb[1][0] = 16'h03E4;
        rv[1][1] = 1'b1; ra[1][1] = 16'h03E4; rb[1][1] = 16'h029D;
        sr[1][0] = 1'b1; sr[1][1] = 1'b1;
        ngrant = 0; seen1 = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (qr[1][1]) seen1 = 1;
            if (qr[1][0]) ngrant++;
            @(negedge clk);
        end
        chk("fp_req1_starved", seen1, 0);
        chk("fp_grant_count", ngrant, 10);
        rv[1][0] = 1'b0;
        #1;
        chk("fp_req1_enters", 32'(qr[1][1]), 1);
        @(negedge clk);
        rv[1][1] = 1'b0;
        @(negedge clk);
        #1;
        chk("fp_rsp1_valid", 32'(sv[1][1]), 1);
        chk("fp_rsp1_product", sp[1][1], 32'h000A_2AD4);
        @(negedge clk);
        idle_inputs();

        // Backpressure on requester 0 while requester 1 waits
        do_reset();
        rv[0][0] = 1'b1; ra[0][0] = 16'h0100; rb[0][0] = 16'hFF00;
        rv[0][1] = 1'b1; ra[0][1] = 16'h0005; rb[0][1] = 16'h0007;
        #1;
        chk("bp_first_tie", 32'(qr[0][0]), 1);
        @(negedge clk);
        rv[0][0] = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_hold_valid", 32'(sv[0][0]), 1);
            chk("bp_hold_product", sp[0][0], 32'hFFFF_0000);
            chk("bp_hold_busy", 32'(bz[0]), 1);
            chk("bp_hold_req1", 32'(qr[0][1]), 0);
            @(negedge clk);
        end
        sr[0][0] = 1'b1;
        @(negedge clk);
        sr[0][0] = 1'b0;
        #1;
        chk("bp_req1_after", 32'(qr[0][1]), 1);
        @(negedge clk);
        rv[0][1] = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_rsp1_valid", 32'(sv[0][1]), 1);
        chk("bp_rsp1_product", sp[0][1], 32'h0000_0023);
        sr[0][1] = 1'b1;
        @(negedge clk);

        // Reset in CALC and in RESP discards the operation
        do_reset();
        rv[0][0] = 1'b1; ra[0][0] = 16'h0003; rb[0][0] = 16'h0004; sr[0][0] = 1'b1;
        @(negedge clk);
        rv[0][0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero(0, "rst_calc");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_calc_quiet", {29'd0, sv[0][0], sv[0][1], bz[0]}, 0);
        end
        @(negedge clk);
        rv[0][1] = 1'b1; ra[0][1] = 16'h0009; rb[0][1] = 16'h0009; sr[0][1] = 1'b0;
        @(negedge clk);
        rv[0][1] = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_resp_pre", 32'(sv[0][1]), 1);
        rst_n = 1'b0;
        #1;
        chk_zero(0, "rst_resp");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_resp_quiet", {29'd0, sv[0][0], sv[0][1], bz[0]}, 0);
        end
        @(negedge clk);
        rv[0][0] = 1'b1; ra[0][0] = 16'h0003; rb[0][0] = 16'h0004;
        rv[0][1] = 1'b1; ra[0][1] = 16'h0005; rb[0][1] = 16'h0006;
        #1;
        chk("rst_tie_req0", 32'(qr[0][0]), 1);
        chk("rst_tie_req1", 32'(qr[0][1]), 0);
        @(negedge clk);
        idle_inputs();

        // Randomized traffic against a transaction-level reference model
        for (int k = 0; k < 2; k++) begin
            do_reset();
            m_busy = 1'b0; m_last = 1; m_owner = 0; m_age = 0; m_prod = '0;
            for (int c = 0; c < 400; c++) begin
                for (int n = 0; n < 2; n++) begin
                    if (rv[k][n] && $urandom_range(15) == 0) begin
                        rv[k][n] = 1'b0;
                    end else if (!rv[k][n] && $urandom_range(2) == 0) begin
                        rv[k][n] = 1'b1;
                        ra[k][n] = rand_op();
                        rb[k][n] = rand_op();
                    end
                    sr[k][n] = 1'($urandom_range(1));
                end
                #1;
                g = -1;
                if (!m_busy) begin
                    if (rv[k][0] && rv[k][1]) g = (k == 0) ? 1 - m_last : 0;
                    else if (rv[k][0])        g = 0;
                    else if (rv[k][1])        g = 1;
                end
                rsp_on = m_busy && (m_age >= 2);
                chk("rnd_ready0", 32'(qr[k][0]), 32'(g == 0));
                chk("rnd_ready1", 32'(qr[k][1]), 32'(g == 1));
                chk("rnd_busy", 32'(bz[k]), 32'(m_busy));
                chk("rnd_rsp0", 32'(sv[k][0]), 32'(rsp_on && m_owner == 0));
                chk("rnd_rsp1", 32'(sv[k][1]), 32'(rsp_on && m_owner == 1));
                if (rsp_on) chk("rnd_product", sp[k][m_owner], m_prod);
                if (g >= 0) begin
                    sa = $signed(ra[k][g]);
                    sb = $signed(rb[k][g]);
                    m_prod  = 32'(sa * sb);
                    m_busy  = 1'b1;
                    m_owner = g;
                    m_last  = g;
                    m_age   = 1;
                end else if (m_busy) begin
                    if (m_age >= 2 && sr[k][m_owner]) m_busy = 1'b0;
                    else m_age++;
                end
                @(negedge clk);
                if (g >= 0) rv[k][g] = 1'b0;
            end
            idle_inputs();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
